bullet_scheduler: RTL and testbench
===================================

Name: bullet_scheduler

Overview:
- Frame-rate controller that shares a fixed pool of bullet datapath slots between the two tank players.
- Each frame it:
  - accepts held fire requests;
  - enforces a per-player cooldown and a per-player live-bullet cap;
  - arbitrates simultaneous requests round-robin;
  - allocates the lowest free slot;
  - issues a one-frame launch command (slot, owner, start position, motion) to the bullet datapath instances.
- Slots are released by per-slot done pulses (wall/iron/tank hit or off-screen) from those instances.

Parameters:
- NUM_SLOTS, 4: bullet datapath instances in the pool (2..8).
- MAX_PER_PLAYER, 2: live bullets allowed per player (1..NUM_SLOTS).
- COOLDOWN, 15: frames between successive grants to the same player.
- SPEED, 5: bullet speed in pixels/frame.

Ports:
- frame_clk  in  1  frame clock; the only clock.
- Reset  in  1  synchronous, active-high reset.
- gaming_on  in  1  game in play; low flushes all state.
- fire_req  in  2  per-player fire key held; bit0 = P1, bit1 = P2.
- dir_p1, dir_p2  in  2 each  facing direction: 00 left, 01 right, 10 down, 11 up.
- tank1_x, tank1_y, tank2_x, tank2_y  in  10 each  tank centre positions.
- slot_done  in  NUM_SLOTS  per-slot release pulse from the bullet datapath.
- launch_valid  out  1  one-frame launch strobe.
- launch_slot  out  3  slot index being launched.
- launch_owner  out  1  0 = P1, 1 = P2.
- launch_x, launch_y  out  10 each  start position (owner tank centre).
- launch_dx, launch_dy  out  10 each  two's-complement motion.
- slot_busy  out  NUM_SLOTS  slot occupied.
- slot_owner  out  NUM_SLOTS  owner bit per slot.
- live_p1, live_p2  out  3 each  live bullet counts.

Behaviour:
- All state updates on posedge frame_clk. Reset is synchronous and active-high.
- Reset values: every output 0; cooldown counters 0; round-robin pointer = P1.
- gaming_on = 0 (sampled each edge):
  - same effect as Reset, except the round-robin pointer is preserved;
  - in-flight bullets are abandoned (slot_busy cleared).
- Eligibility of player p, all combinational from registered state:
  - gaming_on;
  - fire_req[p];
  - cooldown[p] == 0;
  - live_p < MAX_PER_PLAYER;
  - at least one slot with slot_busy == 0.
- Arbitration:
  - one eligible player: that player is granted;
  - both eligible: the player at the rr pointer is granted, and the pointer moves to the other player on any grant;
  - the loser stays eligible and is served next frame if the conditions still hold (no cooldown is charged to the loser).
- Grant at edge N sets the following, all visible at N+1 (latency 1 frame from sampled request to launch_valid):
  - launch_valid = 1 for exactly one frame;
  - launch_slot = lowest-index free slot;
  - slot_busy[slot] = 1 and slot_owner[slot] = p;
  - cooldown[p] = COOLDOWN;
  - launch_x/y = the owner's tank centre sampled at edge N;
  - launch_dx/dy from dir_p: 00 → (-SPEED, 0), 01 → (+SPEED, 0), 10 → (0, +SPEED), 11 → (0, -SPEED).
  - Launch fields hold their last values when launch_valid = 0.
- Cooldown:
  - decrements by 1 each frame while nonzero, saturating at 0;
  - a player holding fire gets a grant every COOLDOWN+1 frames when slots and cap allow.
- Release: slot_done[i] clears slot_busy[i] at the next edge.
  - slot_done on a free slot is ignored.
  - A slot freed at edge N becomes allocatable at N+1, not at N. Free-slot search uses registered slot_busy.
- Simultaneous release of slot i and grant of slot j (j ≠ i) at the same edge: both take effect.
- live_p1/live_p2 are registered population counts of busy slots per owner, consistent with slot_busy in the same frame.
- Pool full, or player at cap: the request is held off with no error and no cooldown charged.
- Reset or gaming_on falling mid-launch: launch_valid is 0 at the next edge.

Decomposition:
- Shared package bullet_pkg:
  - dir_t enum (LEFT, RIGHT, DOWN, UP);
  - owner_t;
  - screen bounds constants (X_MAX 639, Y_MAX 479);
  - a dir_to_motion function (dir, SPEED → dx, dy), shared with the bullet datapath.
- One sub-module: slot_alloc.
  - Combinational lowest-free-index finder over slot_busy.
  - Outputs: any_free and free_idx.

Test Plan:
- Reset, gaming_on = 1, fire_req = 01, dir_p1 = 01, tank1 = (100, 200) → next frame: launch_valid = 1, slot 0, owner 0, x = 100, y = 200, dx = 5, dy = 0; cooldown blocks P1 for 15 frames; next grant 16 frames later in slot 1.
- fire_req = 11 held, MAX_PER_PLAYER = 2, NUM_SLOTS = 4 → grants alternate P1 (slot 0), P2 (slot 1), P1 (slot 2), P2 (slot 3); then no grant; live_p1 = live_p2 = 2.
- Pool full, slot_done[2] pulsed while P1 is eligible → slot_busy[2] clears at edge N; P1 is granted slot 2 at edge N+1, not at N.
- P2 at cap and P1 idle, fire_req = 10 held → no launch and no cooldown charged; on slot_done for a P2 slot, launch follows 1 frame later.
- Both players eligible at the same edge that slot_done[0] arrives, with slot 3 free → grant to the rr-pointer player in slot 3; slot 0 is free afterwards.
- gaming_on dropped with 3 slots busy → next frame: slot_busy = 0, live counts 0, launch_valid = 0; rr pointer retained.

Source files
------------

// File: rtl/bullet_pkg.sv
// Shared types and helpers for the bullet scheduler and the bullet datapath instances.
package bullet_pkg;

  typedef enum logic [1:0] {
    LEFT  = 2'b00,
    RIGHT = 2'b01,
    DOWN  = 2'b10,
    UP    = 2'b11
  } dir_t;

  typedef enum logic {
    P1 = 1'b0,
    P2 = 1'b1
  } owner_t;

  localparam int X_MAX = 639;
  localparam int Y_MAX = 479;

  typedef struct packed {
    logic [9:0] dx;
    logic [9:0] dy;
  } motion_t;

  // Screen y grows downward, so DOWN is +dy and UP is -dy.
  function automatic motion_t dir_to_motion(input dir_t dir, input int speed);
    motion_t    m;
    logic [9:0] s;
    s    = 10'(speed);
    m.dx = '0;
    m.dy = '0;
    case (dir)
      LEFT:  m.dx = -s;
      RIGHT: m.dx = s;
      DOWN:  m.dy = s;
      UP:    m.dy = -s;
      default: ;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/slot_alloc.sv
// Lowest-index free slot finder over the registered busy vector.
module slot_alloc #(
  parameter int NUM_SLOTS = 4,
  parameter int IDX_W     = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] busy,
  output logic                 any_free,
  output logic [IDX_W-1:0]     free_idx
);

  // Scan from the top down so the last hit is the lowest free index.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bullet_scheduler.sv
// Per-frame bullet launch scheduler: cooldown, per-player cap, round-robin arbitration
// and lowest-free-slot allocation over a shared pool of bullet datapath slots.
module bullet_scheduler
  import bullet_pkg::*;
#(
  parameter int NUM_SLOTS      = 4,
  parameter int MAX_PER_PLAYER = 2,
  parameter int COOLDOWN       = 15,
  parameter int SPEED          = 5
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  input  logic                 gaming_on,
  input  logic [1:0]           fire_req,
  input  logic [1:0]           dir_p1,
  input  logic [1:0]           dir_p2,
  input  logic [9:0]           tank1_x,
  input  logic [9:0]           tank1_y,
  input  logic [9:0]           tank2_x,
  input  logic [9:0]           tank2_y,
  input  logic [NUM_SLOTS-1:0] slot_done,
  output logic                 launch_valid,
  output logic [2:0]           launch_slot,
  output logic                 launch_owner,
  output logic [9:0]           launch_x,
  output logic [9:0]           launch_y,
  output logic [9:0]           launch_dx,
  output logic [9:0]           launch_dy,
  output logic [NUM_SLOTS-1:0] slot_busy,
  output logic [NUM_SLOTS-1:0] slot_owner,
  output logic [2:0]           live_p1,
  output logic [2:0]           live_p2
);

  localparam int         IDX_W = $clog2(NUM_SLOTS);
  localparam int         CD_W  = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [3:0] CAP   = 4'(MAX_PER_PLAYER);

  logic [NUM_SLOTS-1:0] busy_reg, busy_next;
  logic [NUM_SLOTS-1:0] owner_reg, owner_next;
  logic [CD_W-1:0]      cd_reg   [2];
  logic [CD_W-1:0]      cd_next  [2];
  logic [3:0]           live_reg [2];
  logic [3:0]           live_next[2];
  owner_t               rr_reg;

  logic                 launch_valid_reg;
  logic [2:0]           launch_slot_reg;
  logic                 launch_owner_reg;
  logic [9:0]           launch_x_reg, launch_y_reg, launch_dx_reg, launch_dy_reg;

  logic                 any_free;
  logic [IDX_W-1:0]     free_idx;
  logic [1:0]           elig;
  logic [1:0]           gnt;
  motion_t              motion;

  slot_alloc #(
    .NUM_SLOTS(NUM_SLOTS),
    .IDX_W    (IDX_W)
  ) u_slot_alloc (
    .busy    (busy_reg),
    .any_free(any_free),
    .free_idx(free_idx)
  );

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_elig
      assign elig[gi] = gaming_on && fire_req[gi] && (cd_reg[gi] == '0) &&
                        (live_reg[gi] < CAP) && any_free;
    end
  endgenerate

  always_comb begin
    gnt        = (elig == 2'b11) ? ((rr_reg == P1) ? 2'b01 : 2'b10) : elig;
    motion     = dir_to_motion(dir_t'(gnt[1] ? dir_p2 : dir_p1), SPEED);
    // Release is applied before allocation; the allocated slot is free in busy_reg,
    // so a release and a grant at the same edge can never collide.
    busy_next  = busy_reg & ~slot_done;
    owner_next = owner_reg;
    if (|gnt) begin
      busy_next[free_idx]  = 1'b1;
      owner_next[free_idx] = gnt[1];
    end
    live_next[0] = '0;
    live_next[1] = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (busy_next[i]) begin
        if (owner_next[i]) live_next[1] = live_next[1] + 4'd1;
        else               live_next[0] = live_next[0] + 4'd1;
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (gnt[p])               cd_next[p] = CD_W'(COOLDOWN);
      else if (cd_reg[p] != '0) cd_next[p] = cd_reg[p] - 1'b1;
      else                      cd_next[p] = cd_reg[p];
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset || !gaming_on) begin
      busy_reg         <= '0;
      owner_reg        <= '0;
      launch_valid_reg <= 1'b0;
      launch_slot_reg  <= '0;
      launch_owner_reg <= 1'b0;
      launch_x_reg     <= '0;
      launch_y_reg     <= '0;
      launch_dx_reg    <= '0;
      launch_dy_reg    <= '0;
      for (int p = 0; p < 2; p++) begin
        cd_reg[p]   <= '0;
        live_reg[p] <= '0;
      end
      // A game-off flush keeps the arbitration fairness state.
      if (Reset) rr_reg <= P1;
    end else begin
      busy_reg         <= busy_next;
      owner_reg        <= owner_next;
      launch_valid_reg <= |gnt;
      for (int p = 0; p < 2; p++) begin
        cd_reg[p]   <= cd_next[p];
        live_reg[p] <= live_next[p];
      end
      if (|gnt) begin
        rr_reg           <= gnt[0] ? P2 : P1;
        launch_slot_reg  <= 3'(free_idx);
        launch_owner_reg <= gnt[1];
        launch_x_reg     <= gnt[1] ? tank2_x : tank1_x;
        launch_y_reg     <= gnt[1] ? tank2_y : tank1_y;
        launch_dx_reg    <= motion.dx;
        launch_dy_reg    <= motion.dy;
      end
    end
  end

  assign launch_valid = launch_valid_reg;
  assign launch_slot  = launch_slot_reg;
  assign launch_owner = launch_owner_reg;
  assign launch_x     = launch_x_reg;
  assign launch_y     = launch_y_reg;
  assign launch_dx    = launch_dx_reg;
  assign launch_dy    = launch_dy_reg;
  assign slot_busy    = busy_reg;
  assign slot_owner   = owner_reg;
  assign live_p1      = live_reg[0][2:0];
  assign live_p2      = live_reg[1][2:0];

endmodule

// File: tb/tb_bullet_scheduler.sv
// Directed bench for bullet_scheduler: launch-field table plus multi-frame scenarios.
module tb_bullet_scheduler;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic       gaming_on;
  logic [1:0] fire_req;
  logic [1:0] dir_p1, dir_p2;
  logic [9:0] tank1_x, tank1_y, tank2_x, tank2_y;
  logic [3:0] slot_done;
  logic       launch_valid;
  logic [2:0] launch_slot;
  logic       launch_owner;
  logic [9:0] launch_x, launch_y, launch_dx, launch_dy;
  logic [3:0] slot_busy, slot_owner;
  logic [2:0] live_p1, live_p2;

  int checks   = 0;
  int failures = 0;

  bullet_scheduler #(
    .NUM_SLOTS     (4),
    .MAX_PER_PLAYER(2),
    .COOLDOWN      (15),
    .SPEED         (5)
  ) dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .gaming_on   (gaming_on),
    .fire_req    (fire_req),
    .dir_p1      (dir_p1),
    .dir_p2      (dir_p2),
    .tank1_x     (tank1_x),
    .tank1_y     (tank1_y),
    .tank2_x     (tank2_x),
    .tank2_y     (tank2_y),
    .slot_done   (slot_done),
    .launch_valid(launch_valid),
    .launch_slot (launch_slot),
    .launch_owner(launch_owner),
    .launch_x    (launch_x),
    .launch_y    (launch_y),
    .launch_dx   (launch_dx),
    .launch_dy   (launch_dy),
    .slot_busy   (slot_busy),
    .slot_owner  (slot_owner),
    .live_p1     (live_p1),
    .live_p2     (live_p2)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic       owner;
    logic [1:0] dir;
    logic [9:0] tx, ty;
    logic [9:0] exp_dx, exp_dy;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic do_reset();
    Reset     = 1'b1;
    gaming_on = 1'b0;
    fire_req  = 2'b00;
    slot_done = 4'b0000;
    step();
    Reset     = 1'b0;
    gaming_on = 1'b1;
  endtask

  // Expect a launch in this frame with the given slot/owner.
  task automatic chk_launch(input string name, input logic [2:0] slot, input logic owner);
    chk({name, "_valid"}, 32'(launch_valid), 32'd1);
    chk({name, "_slot"}, 32'(launch_slot), 32'(slot));
    chk({name, "_owner"}, 32'(launch_owner), 32'(owner));
  endtask

  task automatic idle_frames(input string name, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (launch_valid !== 1'b0) bad++;
    end
    chk({name, "_no_launch"}, 32'(bad), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 2'b01, 10'd100, 10'd200, 10'd5,     10'd0};
    vecs[1] = '{1'b0, 2'b00, 10'd639, 10'd479, 10'h3FB,   10'd0};
    vecs[2] = '{1'b0, 2'b10, 10'd0,   10'd0,   10'd0,     10'd5};
    vecs[3] = '{1'b0, 2'b11, 10'd320, 10'd240, 10'd0,     10'h3FB};
    vecs[4] = '{1'b1, 2'b00, 10'd12,  10'd34,  10'h3FB,   10'd0};
    vecs[5] = '{1'b1, 2'b11, 10'd500, 10'd17,  10'd0,     10'h3FB};
    vecs[6] = '{1'b1, 2'b10, 10'd77,  10'd401, 10'd0,     10'd5};
    vecs[7] = '{1'b1, 2'b01, 10'd1,   10'd2,   10'd5,     10'd0};

    Reset = 1'b1; gaming_on = 1'b0; fire_req = 2'b00; slot_done = 4'b0000;
    dir_p1 = 2'b00; dir_p2 = 2'b00;
    tank1_x = '0; tank1_y = '0; tank2_x = '0; tank2_y = '0;
    step(); step();

    // Reset state
    chk("rst_valid", 32'(launch_valid), 32'd0);
    chk("rst_busy", 32'(slot_busy), 32'd0);
    chk("rst_owner", 32'(slot_owner), 32'd0);
    chk("rst_lives", {29'd0, live_p1} + {29'd0, live_p2}, 32'd0);
    chk("rst_launch_x", 32'(launch_x), 32'd0);

    // Launch field table: each vector starts from reset (which also kills the prior launch)
    for (int v = 0; v < 8; v++) begin
      do_reset();
      chk($sformatf("v%0d_rst_kills_launch", v), 32'(launch_valid), 32'd0);
      fire_req = vecs[v].owner ? 2'b10 : 2'b01;
      dir_p1   = vecs[v].owner ? ~vecs[v].dir : vecs[v].dir;
      dir_p2   = vecs[v].owner ? vecs[v].dir : ~vecs[v].dir;
      tank1_x  = vecs[v].owner ? 10'h155 : vecs[v].tx;
      tank1_y  = vecs[v].owner ? 10'h0AA : vecs[v].ty;
      tank2_x  = vecs[v].owner ? vecs[v].tx : 10'h155;
      tank2_y  = vecs[v].owner ? vecs[v].ty : 10'h0AA;
      step();
      chk_launch($sformatf("v%0d", v), 3'd0, vecs[v].owner);
      chk($sformatf("v%0d_x", v), 32'(launch_x), 32'(vecs[v].tx));
      chk($sformatf("v%0d_y", v), 32'(launch_y), 32'(vecs[v].ty));
      chk($sformatf("v%0d_dx", v), 32'(launch_dx), 32'(vecs[v].exp_dx));
      chk($sformatf("v%0d_dy", v), 32'(launch_dy), 32'(vecs[v].exp_dy));
    end

    // Single player cooldown: grant, 15 blocked frames, then slot 1
    do_reset();
    fire_req = 2'b01; dir_p1 = 2'b01; tank1_x = 10'd100; tank1_y = 10'd200;
    step();
    chk_launch("cd_first", 3'd0, 1'b0);
    chk("cd_first_busy", 32'(slot_busy), 32'h1);
    chk("cd_first_live1", 32'(live_p1), 32'd1);
    idle_frames("cd_block", 15);
    chk("cd_hold_x", 32'(launch_x), 32'd100);
    step();
    chk_launch("cd_second", 3'd1, 1'b0);
    chk("cd_second_live1", 32'(live_p1), 32'd2);

    // Both players held: alternate into slots 0..3, then caps stop grants
    do_reset();
    fire_req = 2'b11; dir_p1 = 2'b11; dir_p2 = 2'b10;
    step(); chk_launch("alt0", 3'd0, 1'b0);
    step(); chk_launch("alt1", 3'd1, 1'b1);
    chk("alt1_dy", 32'(launch_dy), 32'd5);
    idle_frames("alt_cd", 14);
    step(); chk_launch("alt2", 3'd2, 1'b0);
    step(); chk_launch("alt3", 3'd3, 1'b1);
    idle_frames("alt_full", 20);
    chk("alt_busy", 32'(slot_busy), 32'hF);
    chk("alt_owner", 32'(slot_owner), 32'b1010);
    chk("alt_live1", 32'(live_p1), 32'd2);
    chk("alt_live2", 32'(live_p2), 32'd2);

    // Release slot 2 from a full pool: allocatable only one frame later
    slot_done = 4'b0100;
    step();
    slot_done = 4'b0000;
    chk("rel_valid_N", 32'(launch_valid), 32'd0);
    chk("rel_busy_N", 32'(slot_busy), 32'b1011);
    chk("rel_live1_N", 32'(live_p1), 32'd1);
    step();
    chk_launch("rel_N1", 3'd2, 1'b0);
    chk("rel_busy_N1", 32'(slot_busy), 32'hF);
    chk("rel_live1_N1", 32'(live_p1), 32'd2);

    // P2 at cap, P1 idle: held off without cooldown, served right after its slot frees
    fire_req = 2'b10;
    idle_frames("cap_hold", 3);
    slot_done = 4'b0010;
    step();
    slot_done = 4'b0000;
    chk("cap_valid_N", 32'(launch_valid), 32'd0);
    chk("cap_live2_N", 32'(live_p2), 32'd1);
    step();
    chk_launch("cap_N1", 3'd1, 1'b1);
    chk("cap_live2_N1", 32'(live_p2), 32'd2);

    // Simultaneous eligibility with a release in the same edge
    do_reset();
    fire_req = 2'b11;
    step(); chk_launch("sim_a", 3'd0, 1'b0);
    step(); chk_launch("sim_b", 3'd1, 1'b1);
    fire_req = 2'b00;
    idle_frames("sim_wait", 16);
    fire_req = 2'b11; slot_done = 4'b0001;
    step();
    slot_done = 4'b0000;
    chk_launch("sim_grant", 3'd2, 1'b0);
    chk("sim_busy", 32'(slot_busy), 32'b0110);
    chk("sim_owner", 32'(slot_owner), 32'b0010);
    step();
    chk_launch("sim_next", 3'd0, 1'b1);
    chk("sim_live2", 32'(live_p2), 32'd2);

    // Set rr to P2, build 3 busy slots, then drop gaming_on
    fire_req = 2'b00;
    idle_frames("go_wait", 16);
    fire_req = 2'b01;
    step(); chk_launch("go_p1", 3'd3, 1'b0);
    fire_req = 2'b00; slot_done = 4'b0001;
    step();
    slot_done = 4'b0000;
    chk("go_busy3", 32'(slot_busy), 32'b1110);
    chk("go_live1", 32'(live_p1), 32'd2);
    chk("go_live2", 32'(live_p2), 32'd1);
    gaming_on = 1'b0;
    step();
    chk("off_valid", 32'(launch_valid), 32'd0);
    chk("off_busy", 32'(slot_busy), 32'd0);
    chk("off_owner", 32'(slot_owner), 32'd0);
    chk("off_lives", {29'd0, live_p1} + {29'd0, live_p2}, 32'd0);
    chk("off_launch_x", 32'(launch_x), 32'd0);
    gaming_on = 1'b1; fire_req = 2'b11;
    step();
    chk_launch("off_rr_kept", 3'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
